// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle add/sub/and/or/slt plus an iterative
// shift-add multiplier. Results are registered and announced by a one-cycle
// valid_o pulse; busy_o stalls the pipeline while a multiply runs.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             illegal_o
);

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_MUL = 3'b100;

  // Counter must hold WIDTH-1; one spare bit keeps it safe for any WIDTH.
  localparam int              CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               zero_q, zero_d;
  logic               valid_q, valid_d;
  logic               illegal_q, illegal_d;

  logic [WIDTH-1:0]   single_res;
  logic [WIDTH-1:0]   acc_sum;

  // Result of the one-cycle ops; slt compares operands as two's complement.
  function automatic logic [WIDTH-1:0] alu_single(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    a_s = $signed(a);
    b_s = $signed(b);
    case (op)
      OP_ADD:  alu_single = a + b;
      OP_SUB:  alu_single = a - b;
      OP_AND:  alu_single = a & b;
      OP_OR:   alu_single = a | b;
      OP_SLT:  alu_single = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      default: alu_single = '0;
    endcase
  endfunction

  function automatic logic is_single(input logic [2:0] op);
    is_single = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                (op == OP_OR)  || (op == OP_SLT);
  endfunction

  assign single_res = alu_single(ALUCtrl_i, data1_i, data2_i);
  // Partial product for this iteration; on the last step it is the final product.
  assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state and result selection for the IDLE/MUL controller.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    data_d    = data_q;
    zero_d    = zero_q;
    valid_d   = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else if (is_single(ALUCtrl_i)) begin
            data_d    = single_res;
            zero_d    = (single_res == '0);
            valid_d   = 1'b1;
            illegal_d = 1'b0;
          end else begin
            data_d    = '0;
            zero_d    = 1'b1;
            valid_d   = 1'b1;
            illegal_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Fixed WIDTH iterations, no early exit on a zero multiplier.
        if (cnt_q == LAST) begin
          data_d    = acc_sum;
          zero_d    = (acc_sum == '0);
          valid_d   = 1'b1;
          illegal_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible result registers; reset aborts any multiply in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      zero_q    <= 1'b1;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  // Multiplier datapath; contents are don't-care outside MUL, so no reset.
  always_ff @(posedge clk_i) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
  end

  assign data_o    = data_q;
  assign zero_o    = zero_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q == MUL);
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: expected results are queued when an op is
// issued and popped when valid_o is seen. Inputs change and outputs are
// sampled on the falling edge.
module tb_alu_multicycle;

  localparam int W = 32;
  localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AND_ = 3'b000,
                         OR_ = 3'b001, SLT = 3'b111, MULOP = 3'b100;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   ctrl;
  logic [W-1:0] a, b;
  logic [W-1:0] data_o;
  logic         zero_o, valid_o, busy_o, illegal_o;

  typedef struct packed {
    logic [W-1:0] d;
    logic         z;
    logic         ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ALUCtrl_i(ctrl),
    .data1_i(a), .data2_i(b), .data_o(data_o), .zero_o(zero_o),
    .valid_o(valid_o), .busy_o(busy_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ctrl = ADD; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) rst = 1'b0;
      @(negedge clk);
      total++; if (data_o !== '0)     $display("FAIL reset_data[%0d]: got %h want 0", i, data_o); else passed++;
      total++; if (zero_o !== 1'b1)   $display("FAIL reset_zero[%0d]: got %b want 1", i, zero_o); else passed++;
      total++; if (valid_o !== 1'b0)  $display("FAIL reset_valid[%0d]: got %b want 0", i, valid_o); else passed++;
      total++; if (busy_o !== 1'b0)   $display("FAIL reset_busy[%0d]: got %b want 0", i, busy_o); else passed++;
      total++; if (illegal_o !== 1'b0) $display("FAIL reset_illegal[%0d]: got %b want 0", i, illegal_o); else passed++;
    end
  endtask

  task automatic test_single_ops();
    logic [2:0]   op  [6];
    logic [W-1:0] opa [6];
    logic [W-1:0] opb [6];
    logic [W-1:0] res [6];
    op  = '{ADD, SUB, AND_, OR_, SLT, SLT};
    opa = '{32'd7, 32'd5, 32'h0000_F0F0, 32'h0000_F0F0, 32'hFFFF_FFFF, 32'd3};
    opb = '{32'd5, 32'd7, 32'h0000_0FF0, 32'h0000_0FF0, 32'd3, 32'hFFFF_FFFF};
    res = '{32'd12, 32'hFFFF_FFFE, 32'h0000_00F0, 32'h0000_FFF0, 32'd1, 32'd0};
    for (int i = 0; i < 6; i++) begin
      e.d = res[i]; e.z = (res[i] == 0); e.ill = 1'b0;
      exp_q.push_back(e);
      start = 1'b1; ctrl = op[i]; a = opa[i]; b = opb[i];
      @(negedge clk);
      total++; if (valid_o !== 1'b1) $display("FAIL single_valid[%0d]: got %b want 1", i, valid_o); else passed++;
      if (exp_q.size() == 0) begin
        total++; $display("FAIL single_sb[%0d]: got empty queue want entry", i);
      end else begin
        e = exp_q.pop_front();
        total++; if (data_o !== e.d)      $display("FAIL single_data[%0d]: got %h want %h", i, data_o, e.d); else passed++;
        total++; if (zero_o !== e.z)      $display("FAIL single_zero[%0d]: got %b want %b", i, zero_o, e.z); else passed++;
        total++; if (illegal_o !== e.ill) $display("FAIL single_illegal[%0d]: got %b want %b", i, illegal_o, e.ill); else passed++;
      end
    end
    start = 1'b0;
    @(negedge clk);
    total++; if (valid_o !== 1'b0) $display("FAIL single_valid_drop: got %b want 0", valid_o); else passed++;
    total++; if (data_o !== '0)    $display("FAIL single_hold: got %h want 0", data_o); else passed++;
  endtask

  task automatic test_mul(input logic [W-1:0] ma, input logic [W-1:0] mb);
    int k, busy_n;
    e.d = ma * mb; e.z = (e.d == 0); e.ill = 1'b0;
    exp_q.push_back(e);
    start = 1'b1; ctrl = MULOP; a = ma; b = mb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    k = 0; busy_n = 0;
    while (!valid_o && k < 40) begin
      if (busy_o) busy_n++;
      @(negedge clk);
      k++;
      a = $urandom; b = $urandom;
    end
    total++; if (k != 32)      $display("FAIL mul_latency: got %0d edges want 32", k); else passed++;
    total++; if (busy_n != 32) $display("FAIL mul_busy_cycles: got %0d want 32", busy_n); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL mul_busy_at_valid: got %b want 0", busy_o); else passed++;
    if (!valid_o) begin
      total++; $display("FAIL mul_timeout: got no valid_o want pulse");
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      total++; if (data_o !== e.d)      $display("FAIL mul_data: got %h want %h", data_o, e.d); else passed++;
      total++; if (zero_o !== e.z)      $display("FAIL mul_zero: got %b want %b", zero_o, e.z); else passed++;
      total++; if (illegal_o !== e.ill) $display("FAIL mul_illegal: got %b want %b", illegal_o, e.ill); else passed++;
    end
    @(negedge clk);
    total++; if (valid_o !== 1'b0) $display("FAIL mul_valid_drop: got %b want 0", valid_o); else passed++;
  endtask

  task automatic test_busy_ignore();
    logic [2:0] pick [6];
    int k, early;
    pick = '{ADD, SUB, AND_, OR_, SLT, MULOP};
    e.d = 32'd200; e.z = 1'b0; e.ill = 1'b0;
    exp_q.push_back(e);
    start = 1'b1; ctrl = MULOP; a = 32'd10; b = 32'd20;
    k = 0; early = 0;
    @(negedge clk);
    while (!valid_o && k < 40) begin
      if (!busy_o) early++;
      ctrl = pick[$urandom_range(5, 0)]; a = $urandom; b = $urandom;
      @(negedge clk);
      k++;
    end
    total++; if (early != 0) $display("FAIL busy_hold: got %0d non-busy cycles want 0", early); else passed++;
    total++; if (k != 32)    $display("FAIL busy_latency: got %0d edges want 32", k); else passed++;
    if (!valid_o) begin
      total++; $display("FAIL busy_timeout: got no valid_o want pulse");
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      total++; if (data_o !== e.d) $display("FAIL busy_data: got %h want %h", data_o, e.d); else passed++;
    end
    // New request issued in the completion cycle must be taken immediately.
    e.d = 32'd2; e.z = 1'b0; e.ill = 1'b0;
    exp_q.push_back(e);
    ctrl = ADD; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    total++; if (valid_o !== 1'b1) $display("FAIL b2b_valid: got %b want 1", valid_o); else passed++;
    e = exp_q.pop_front();
    total++; if (data_o !== e.d) $display("FAIL b2b_data: got %h want %h", data_o, e.d); else passed++;
    @(negedge clk);
    total++; if (valid_o !== 1'b0) $display("FAIL b2b_valid_drop: got %b want 0", valid_o); else passed++;
  endtask

  task automatic test_reset_abort();
    int pulses;
    start = 1'b1; ctrl = MULOP; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    total++; if (busy_o !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy_o); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy_o !== 1'b0)    $display("FAIL abort_busy: got %b want 0", busy_o); else passed++;
    total++; if (data_o !== '0)      $display("FAIL abort_data: got %h want 0", data_o); else passed++;
    total++; if (zero_o !== 1'b1)    $display("FAIL abort_zero: got %b want 1", zero_o); else passed++;
    total++; if (valid_o !== 1'b0)   $display("FAIL abort_valid: got %b want 0", valid_o); else passed++;
    pulses = 0;
    repeat (35) begin
      @(negedge clk);
      if (valid_o) pulses++;
    end
    total++; if (pulses != 0) $display("FAIL abort_no_pulse: got %0d pulses want 0", pulses); else passed++;
    e.d = 32'd5; e.z = 1'b0; e.ill = 1'b0;
    exp_q.push_back(e);
    start = 1'b1; ctrl = ADD; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    total++; if (valid_o !== 1'b1) $display("FAIL abort_add_valid: got %b want 1", valid_o); else passed++;
    e = exp_q.pop_front();
    total++; if (data_o !== e.d) $display("FAIL abort_add_data: got %h want %h", data_o, e.d); else passed++;
  endtask

  task automatic test_illegal();
    logic [2:0] op [3];
    op = '{3'b011, 3'b101, ADD};
    e.d = '0; e.z = 1'b1; e.ill = 1'b1;
    exp_q.push_back(e); exp_q.push_back(e);
    e.d = 32'd8; e.z = 1'b0; e.ill = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; ctrl = op[i]; a = 32'd4; b = 32'd4;
      @(negedge clk);
      total++; if (valid_o !== 1'b1) $display("FAIL illegal_valid[%0d]: got %b want 1", i, valid_o); else passed++;
      if (exp_q.size() == 0) begin
        total++; $display("FAIL illegal_sb[%0d]: got empty queue want entry", i);
      end else begin
        e = exp_q.pop_front();
        total++; if (data_o !== e.d)      $display("FAIL illegal_data[%0d]: got %h want %h", i, data_o, e.d); else passed++;
        total++; if (zero_o !== e.z)      $display("FAIL illegal_zero[%0d]: got %b want %b", i, zero_o, e.z); else passed++;
        total++; if (illegal_o !== e.ill) $display("FAIL illegal_flag[%0d]: got %b want %b", i, illegal_o, e.ill); else passed++;
      end
    end
    start = 1'b0;
    @(negedge clk);
    total++; if (valid_o !== 1'b0) $display("FAIL illegal_valid_drop: got %b want 0", valid_o); else passed++;
    total++; if (data_o !== 32'd8) $display("FAIL illegal_hold: got %h want 8", data_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_mul(32'd123, 32'd456);
    test_mul(32'hFFFF_FFFF, 32'd2);
    test_busy_ignore();
    test_reset_abort();
    test_illegal();
    total++; if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
